multi_cycle_ctrl: RTL and testbench

Multi-cycle MIPS control unit. It sequences a shared-ALU, unified-memory datapath through the fetch, decode, execute, memory and writeback states. The datapath holds IR, A, B, ALUOut and MDR and uses the existing 4-bit ALU op encoding. It supports the same instruction set as the single-cycle core and adds a memory ready handshake, an illegal-opcode trap and a memory timeout trap.

---
 rtl/multi_cycle_ctrl_if.sv | 35 +++
 rtl/multi_cycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: control-unit to datapath/memory signal bundle.
// master = control unit, slave = datapath and memory.
interface multi_cycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       sz_en;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       halted;
    logic [1:0] err_code;

    modport master (
        input  op, func, zero, mem_ready,
        output mem_req, iord, mem_write, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
               alu_op, sz_en, reg_dst, mem_to_reg, reg_write, halted, err_code
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  mem_req, iord, mem_write, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
               alu_op, sz_en, reg_dst, mem_to_reg, reg_write, halted, err_code
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS control FSM with memory handshake, illegal-op and timeout traps.
// Optional cycle/instruction counters are built when MC_PERF_CNT_EN is defined.
module multi_cycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic clk,
    input  logic reset,
    multi_cycle_ctrl_if.master bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd2, A_SLTU = 4'd3, A_AND = 4'd4,
                           A_OR = 4'd5, A_NOR = 4'd6, A_XOR = 4'd7, A_LUI = 4'd8;
    localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] TMO_LAST = W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        FETCH, DECODE, REXE, RWB, IEXE, IWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, HALT
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] err_q, err_d;
    logic [W-1:0] wait_q, wait_d;
    logic       r_ok, i_sz, timeout;
    logic [3:0] r_op, i_op;

    always_comb begin
        r_ok = 1'b1;
        r_op = A_ADD;
        case (bus.func)
            6'h20, 6'h21: r_op = A_ADD;
            6'h22, 6'h23: r_op = A_SUB;
            6'h24:        r_op = A_AND;
            6'h25:        r_op = A_OR;
            6'h26:        r_op = A_XOR;
            6'h27:        r_op = A_NOR;
            6'h2A:        r_op = A_SLT;
            6'h2B:        r_op = A_SLTU;
            default:      r_ok = 1'b0;
        endcase
    end

    // I-type ops 0x08-0x0F: low three op bits select the ALU function
    always_comb begin
        i_op = A_LUI;
        i_sz = ~bus.op[2];
        case (bus.op[2:0])
            3'd0, 3'd1: i_op = A_ADD;
            3'd2:       i_op = A_SLT;
            3'd3:       i_op = A_SLTU;
            3'd4:       i_op = A_AND;
            3'd5:       i_op = A_OR;
            3'd6:       i_op = A_XOR;
            default:    i_op = A_LUI;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        err_d          = err_q;
        timeout        = (MEM_TIMEOUT != 0) && (wait_q == TMO_LAST) && !bus.mem_ready;
        bus.mem_req    = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.alu_op     = A_ADD;
        bus.sz_en      = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        case (state_q)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                state_d       = bus.mem_ready ? DECODE : timeout ? HALT : FETCH;
            end
            DECODE: begin
                bus.alu_src_b = 2'd3;
                bus.sz_en     = 1'b1;
                state_d       = (bus.op == 6'h00) ? (r_ok ? REXE : HALT) :
                                (bus.op == 6'h23 || bus.op == 6'h2B) ? MEMADR :
                                (bus.op == 6'h04 || bus.op == 6'h05) ? BRANCH :
                                (bus.op[5:3] == 3'b001) ? IEXE : HALT;
            end
            REXE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = r_op;
                state_d       = RWB;
            end
            IEXE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = i_op;
                bus.sz_en     = i_sz;
                state_d       = IWB;
            end
            RWB, IWB, MEMWB: begin
                bus.reg_dst    = (state_q == RWB);
                bus.mem_to_reg = (state_q == MEMWB);
                bus.reg_write  = 1'b1;
                state_d        = FETCH;
            end
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.sz_en     = 1'b1;
                state_d       = (bus.op == 6'h23) ? MEMRD : MEMWR;
            end
            MEMRD, MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.iord      = 1'b1;
                bus.mem_write = (state_q == MEMWR);
                state_d       = bus.mem_ready ? ((state_q == MEMRD) ? MEMWB : FETCH) :
                                timeout ? HALT : state_q;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = A_SUB;
                bus.pc_src    = 1'b1;
                bus.pc_write  = bus.op[0] ? ~bus.zero : bus.zero;
                state_d       = FETCH;
            end
            default: state_d = HALT;
        endcase
        if (state_q != HALT && state_d == HALT)
            err_d = (state_q == DECODE) ? 2'd1 : 2'd2;
        wait_d = (state_d != state_q) ? '0 :
                 ((state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !bus.mem_ready) ?
                 wait_q + W'(1) : wait_q;
        // the FETCH strobes are Mealy on mem_ready, so they must be masked while reset is high
        if (reset) begin
            bus.mem_write = 1'b0;
            bus.ir_write  = 1'b0;
            bus.pc_write  = 1'b0;
            bus.reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            err_q   <= 2'd0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.halted   = (state_q == HALT);
    assign bus.err_code = err_q;

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (state_q != HALT) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (state_d == FETCH && (state_q == RWB || state_q == IWB || state_q == MEMWB ||
                                     state_q == MEMWR || state_q == BRANCH))
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed per-cycle scoreboard bench for multi_cycle_ctrl (MEM_TIMEOUT = 4).
module tb_multi_cycle_ctrl;
    typedef struct {
        string       n;
        logic [19:0] v;
        logic [19:0] m;
    } exp_t;

    // packed layout: mem_req iord mem_write ir_write pc_write pc_src alu_src_a alu_src_b[2]
    //                alu_op[4] sz_en reg_dst mem_to_reg reg_write halted err_code[2]
    localparam logic [19:0] MS = 20'hB800F, M_IO = 20'h40000, M_PCS = 20'h04000, M_ASA = 20'h02000,
                            M_ASB = 20'h01800, M_AOP = 20'h00780, M_SZ = 20'h00040,
                            M_RD = 20'h00020, M_M2R = 20'h00010;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [19:0] got;

    multi_cycle_ctrl_if bus();

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc, ins;
    multi_cycle_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus),
                                             .cycle_cnt(cyc), .instr_cnt(ins));
`else
    multi_cycle_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;

    assign got = {bus.mem_req, bus.iord, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_src,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.sz_en, bus.reg_dst,
                  bus.mem_to_reg, bus.reg_write, bus.halted, bus.err_code};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ((got & e.m) !== (e.v & e.m)) begin
                failures++;
                $display("FAIL %s got=%05h exp=%05h mask=%05h", e.n, got & e.m, e.v & e.m, e.m);
            end
        end
    end

    task automatic step(string n, logic [19:0] v, logic [19:0] m, logic rdy, logic z);
        bus.mem_ready = rdy;
        bus.zero      = z;
        sb.push_back('{n, v, m});
        @(posedge clk);
        #1;
    endtask

    task automatic s_f(string n, logic rdy, logic stb);
        step(n, {1'b1, 1'b0, 1'b0, stb, stb, 1'b0, 1'b0, 2'd1, 4'd0, 5'd0, 2'd0},
             MS | M_IO | M_PCS | M_ASA | M_ASB | M_AOP, rdy, 1'b0);
    endtask
    task automatic s_d(string n);
        step(n, {7'd0, 2'd3, 4'd0, 1'b1, 4'd0, 2'd0}, MS | M_ASA | M_ASB | M_AOP | M_SZ, 1'b0, 1'b0);
    endtask
    task automatic s_x(string n, logic [1:0] asb, logic [3:0] aop, logic sz);
        step(n, {6'd0, 1'b1, asb, aop, sz, 4'd0, 2'd0}, MS | M_ASA | M_ASB | M_AOP | M_SZ, 1'b0, 1'b0);
    endtask
    task automatic s_wb(string n, logic rd, logic m2r);
        step(n, {15'd0, rd, m2r, 1'b1, 1'b0, 2'd0}, MS | M_RD | M_M2R, 1'b0, 1'b0);
    endtask
    task automatic s_mem(string n, logic wr, logic rdy);
        step(n, {1'b1, 1'b1, wr, 17'd0}, MS | M_IO, rdy, 1'b0);
    endtask
    task automatic s_br(string n, logic z, logic pcw);
        step(n, {4'd0, pcw, 1'b1, 1'b1, 2'd0, 4'd1, 7'd0}, MS | M_PCS | M_ASA | M_ASB | M_AOP, 1'b0, z);
    endtask
    task automatic s_h(string n, logic [1:0] ec, logic rdy);
        step(n, {17'd0, 1'b1, ec}, MS, rdy, 1'b0);
    endtask
    task automatic do_reset(string n);
        reset = 1'b1;
        s_f(n, 1'b1, 1'b0);
        reset = 1'b0;
    endtask

    logic [5:0] rf[8] = '{6'h20, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [3:0] ra[8] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd7, 4'd6, 4'd2, 4'd3};
    logic [5:0] io[7] = '{6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [3:0] ia[7] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
    logic       is[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [5:0] bo[4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       bz[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       bp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b0;
        bus.op = 6'h00;
        bus.func = 6'h20;
        @(posedge clk);
        #1;
        do_reset("reset");
`ifdef MC_PERF_CNT_EN
        checks++;
        if (cyc !== 32'd0 || ins !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset got=%0d/%0d exp=0/0", cyc, ins);
        end
`endif
        for (int i = 0; i < 8; i++) begin
            bus.op = 6'h00;
            bus.func = rf[i];
            s_f($sformatf("r%0d.fetch", i), 1'b1, 1'b1);
            s_d($sformatf("r%0d.decode", i));
            s_x($sformatf("r%0d.rexe", i), 2'd0, ra[i], 1'b0);
            s_wb($sformatf("r%0d.rwb", i), 1'b1, 1'b0);
        end
        for (int i = 0; i < 7; i++) begin
            bus.op = io[i];
            s_f($sformatf("i%0d.fetch", i), 1'b1, 1'b1);
            s_d($sformatf("i%0d.decode", i));
            s_x($sformatf("i%0d.iexe", i), 2'd2, ia[i], is[i]);
            s_wb($sformatf("i%0d.iwb", i), 1'b0, 1'b0);
        end
        bus.op = 6'h23;
        s_f("lw.fetch_wait0", 1'b0, 1'b0);
        s_f("lw.fetch_wait1", 1'b0, 1'b0);
        s_f("lw.fetch", 1'b1, 1'b1);
        s_d("lw.decode");
        s_x("lw.memadr", 2'd2, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) s_mem($sformatf("lw.memrd_wait%0d", i), 1'b0, 1'b0);
        s_mem("lw.memrd_done", 1'b0, 1'b1);
        s_wb("lw.memwb", 1'b0, 1'b1);
        bus.op = 6'h2B;
        s_f("sw.fetch", 1'b1, 1'b1);
        s_d("sw.decode");
        s_x("sw.memadr", 2'd2, 4'd0, 1'b1);
        s_mem("sw.memwr", 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.op = bo[i];
            s_f($sformatf("b%0d.fetch", i), 1'b1, 1'b1);
            s_d($sformatf("b%0d.decode", i));
            s_br($sformatf("b%0d.branch", i), bz[i], bp[i]);
        end
        bus.op = 6'h00;
        bus.func = 6'h20;
        for (int i = 0; i < 4; i++) s_f($sformatf("tmo.fetch_wait%0d", i), 1'b0, 1'b0);
        s_h("tmo.halt0", 2'd2, 1'b1);
        s_h("tmo.halt1", 2'd2, 1'b1);
        s_h("tmo.halt2", 2'd2, 1'b0);
        do_reset("tmo.reset");
        bus.op = 6'h3F;
        for (int i = 0; i < 3; i++) s_f($sformatf("race.fetch_wait%0d", i), 1'b0, 1'b0);
        s_f("race.fetch_ready", 1'b1, 1'b1);
        s_d("race.decode");
        s_h("ill.halt0", 2'd1, 1'b1);
        s_h("ill.halt1", 2'd1, 1'b1);
        do_reset("ill.reset");
        bus.op = 6'h00;
        bus.func = 6'h01;
        s_f("badfn.fetch", 1'b1, 1'b1);
        s_d("badfn.decode");
        s_h("badfn.halt", 2'd1, 1'b0);
        do_reset("badfn.reset");
        bus.op = 6'h2B;
        s_f("swr.fetch", 1'b1, 1'b1);
        s_d("swr.decode");
        s_x("swr.memadr", 2'd2, 4'd0, 1'b1);
        s_mem("swr.memwr_wait0", 1'b1, 1'b0);
        s_mem("swr.memwr_wait1", 1'b1, 1'b0);
        reset = 1'b1;
        s_f("swr.in_reset", 1'b0, 1'b0);
`ifdef MC_PERF_CNT_EN
        checks++;
        if (cyc !== 32'd0 || ins !== 32'd0) begin
            failures++;
            $display("FAIL perf_midreset got=%0d/%0d exp=0/0", cyc, ins);
        end
`endif
        reset = 1'b0;
        s_f("swr.fetch_after", 1'b1, 1'b1);
        s_d("swr.decode_after");
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
